// File: rtl/pipelined_addsub_if.sv
// Streaming handshake bundle for pipelined_addsub.
// out_ovf exists only when ADDSUB_OVERFLOW_FLAG_EN is defined.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum
    );
`endif
endinterface

// File: rtl/pipelined_addsub.sv
// Fully registered adder/subtractor with the carry chain split into STAGES segments.
// Optional signed-overflow output is enabled with ADDSUB_OVERFLOW_FLAG_EN.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic               clock,
    input logic               reset,
    pipelined_addsub_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_config
        $fatal(1, "pipelined_addsub: WIDTH=%0d must be divisible by STAGES=%0d (1..WIDTH)",
               WIDTH, STAGES);
    end

    // Index 0 is the input register, index STAGES is the output register.
    logic [WIDTH-1:0] a_q     [0:STAGES-1];
    logic [WIDTH-1:0] b_q     [0:STAGES-1];
    logic [WIDTH-1:0] sum_q   [0:STAGES];
    logic             carry_q [0:STAGES];
    logic             sub_q   [0:STAGES];
    logic             valid_q [0:STAGES];

    logic [SEG:0]     seg_res [1:STAGES];
    logic [WIDTH-1:0] sum_d   [1:STAGES];
    logic             advance;

`ifdef ADDSUB_OVERFLOW_FLAG_EN
    logic             msb_carry_d;
    logic             msb_carry_q;
`endif

    // Each stage adds one segment and merges it onto the finished low bits from the stage before.
    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            seg_res[k] = {1'b0, a_q[k-1][(k-1)*SEG +: SEG]}
                       + {1'b0, b_q[k-1][(k-1)*SEG +: SEG]}
                       + {{SEG{1'b0}}, carry_q[k-1]};
            sum_d[k]   = sum_q[k-1] | (WIDTH'(seg_res[k][SEG-1:0]) << ((k-1)*SEG));
        end
    end

`ifdef ADDSUB_OVERFLOW_FLAG_EN
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    always_comb begin
        msb_carry_d = sum_d[STAGES][WIDTH-1] ^ a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1];
    end
`endif

    assign advance = !valid_q[STAGES] || bus.out_ready;

    // Whole-pipe stall: nothing moves unless the output is empty or being taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k <= STAGES; k++) begin
                valid_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                sub_q[k]   <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
`ifdef ADDSUB_OVERFLOW_FLAG_EN
            msb_carry_q <= 1'b0;
`endif
        end else if (advance) begin
            valid_q[0] <= bus.in_valid;
            a_q[0]     <= bus.in_a;
            b_q[0]     <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_q[0] <= bus.in_sub;
            sub_q[0]   <= bus.in_sub;
            sum_q[0]   <= '0;

            for (int k = 1; k <= STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                if (k < STAGES || valid_q[k-1]) begin
                    sum_q[k]   <= sum_d[k];
                    carry_q[k] <= seg_res[k][SEG];
                    sub_q[k]   <= sub_q[k-1];
                end
            end

            // Consumed low operand bits are zeroed so only the upper part travels on.
            for (int k = 1; k < STAGES; k++) begin
                a_q[k] <= a_q[k-1] & ({WIDTH{1'b1}} << (k * SEG));
                b_q[k] <= b_q[k-1] & ({WIDTH{1'b1}} << (k * SEG));
            end

`ifdef ADDSUB_OVERFLOW_FLAG_EN
            if (valid_q[STAGES-1]) begin
                msb_carry_q <= msb_carry_d;
            end
`endif
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[STAGES];
    // Subtraction reports borrow, which is the inverted final carry.
    assign bus.out_sum   = {carry_q[STAGES] ^ sub_q[STAGES], sum_q[STAGES]};

`ifdef ADDSUB_OVERFLOW_FLAG_EN
    assign bus.out_ovf   = carry_q[STAGES] ^ msb_carry_q;
`endif

endmodule
